// File: rtl/lif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lif_pkg                                                         |
// | Brief    : Shared types, defaults and saturating helpers for the LIF tile. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;
    localparam int W_MAX = 16;

    typedef logic [W_MAX-1:0] word_t;

    // Operands are zero-extended to W_MAX; max carries the caller's ceiling.
    function automatic word_t sat_add(input word_t a, input word_t b, input word_t max);
        logic [W_MAX:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[W_MAX-1:0];
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lif_core                                                        |
// | Brief    : Combinational leak/integrate/fire update for a single neuron.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lif_core
    import lif_pkg::*;
#(
    parameter int           W        = W_DEF,
    parameter logic [W-1:0] THR_STEP = W'(16)
) (
    input  logic [W-1:0] v,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] off,
    input  logic [W-1:0] thr_base,
    input  logic [2:0]   beta_shift,
    input  logic         adapt_en,
    output logic [W-1:0] v_next,
    output logic [W-1:0] off_next,
    output logic         fire
);

    localparam word_t c_max = word_t'((32'd1 << W) - 32'd1);

    logic [W-1:0] w_leak;
    logic [W-1:0] w_vl;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_eff_thr;

    assign w_leak    = v >> beta_shift;
    assign w_vl      = v - w_leak;
    assign w_sum     = W'(sat_add(word_t'(w_vl), word_t'(cur), c_max));
    assign w_eff_thr = W'(sat_add(word_t'(thr_base), word_t'(off), c_max));
    assign fire      = (w_sum >= w_eff_thr);
    assign v_next    = fire ? '0 : w_sum;

    // With adaptation disabled the offset is frozen but still biases the threshold.
    always_comb begin
        off_next = off;
        if (adapt_en) begin
            if (fire) off_next = W'(sat_add(word_t'(off), word_t'(THR_STEP), c_max));
            else      off_next = W'(sat_sub(word_t'(off), word_t'(1)));
        end
    end

endmodule
`default_nettype wire

// File: rtl/lif_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lif_scheduler                                                   |
// | Brief    : Time-multiplexes one LIF datapath across N neurons per step.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int           N        = N_DEF,
    parameter int           W        = W_DEF,
    parameter logic [W-1:0] THR_STEP = W'(16)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*W-1:0]       current_in,
    input  logic [W-1:0]         thr_base,
    input  logic [2:0]           beta_shift,
    input  logic                 adapt_en,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         spikes,
    output logic                 evt_valid,
    output logic [$clog2(N)-1:0] evt_idx,
    input  logic                 evt_ready,
    input  logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         state_out
);

    localparam int IW = $clog2(N);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_v   [N];
    logic [W-1:0]    r_off [N];
    logic [N-1:0]    r_work;
    logic [N-1:0]    r_spikes;
    logic            r_evt_valid;
    logic [IW-1:0]   r_evt_idx;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_state_out;

    logic [W-1:0]    w_v_next;
    logic [W-1:0]    w_off_next;
    logic            w_fire;
    logic            w_drain;
    logic            w_commit;
    logic [N-1:0]    w_work_next;

    lif_core #(
        .W        (W),
        .THR_STEP (THR_STEP)
    ) u_core (
        .v          (r_v[r_idx]),
        .cur        (current_in[int'(r_idx)*W +: W]),
        .off        (r_off[r_idx]),
        .thr_base   (thr_base),
        .beta_shift (beta_shift),
        .adapt_en   (adapt_en),
        .v_next     (w_v_next),
        .off_next   (w_off_next),
        .fire       (w_fire)
    );

    // A spike may only commit if the event slot is free or emptying this cycle.
    assign w_drain     = r_evt_valid & evt_ready;
    assign w_commit    = (r_state == UPDATE) & ~(w_fire & r_evt_valid & ~evt_ready);
    assign w_work_next = r_work | (w_fire ? (N'(1) << r_idx) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_work      <= '0;
            r_spikes    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_state_out <= '0;
            for (int k = 0; k < N; k++) begin
                r_v[k]   <= '0;
                r_off[k] <= '0;
            end
        end else begin
            r_state_out <= r_v[sel];
            r_done      <= 1'b0;

            if (w_commit && w_fire) begin
                r_evt_valid <= 1'b1;
                r_evt_idx   <= r_idx;
            end else if (w_drain) begin
                r_evt_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= UPDATE;
                        r_idx   <= '0;
                        r_work  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (w_commit) begin
                        r_v[r_idx]   <= w_v_next;
                        r_off[r_idx] <= w_off_next;
                        r_work       <= w_work_next;
                        if (r_idx == IW'(N - 1)) r_state <= DONE;
                        else                     r_idx   <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_idx    <= '0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_spikes <= r_work;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign spikes    = r_spikes;
    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign state_out = r_state_out;

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lif_scheduler                                                |
// | Brief    : Directed self-checking bench for lif_scheduler (N=4, W=8).      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_lif_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N*W-1:0] current_in;
    logic [W-1:0]   thr_base;
    logic [2:0]     beta_shift;
    logic           adapt_en;
    logic           busy;
    logic           done;
    logic [N-1:0]   spikes;
    logic           evt_valid;
    logic [IW-1:0]  evt_idx;
    logic           evt_ready;
    logic [IW-1:0]  sel;
    logic [W-1:0]   state_out;

    int total = 0;
    int bad   = 0;

    lif_scheduler #(.N(N), .W(W), .THR_STEP(8'd16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .current_in (current_in),
        .thr_base   (thr_base),
        .beta_shift (beta_shift),
        .adapt_en   (adapt_en),
        .busy       (busy),
        .done       (done),
        .spikes     (spikes),
        .evt_valid  (evt_valid),
        .evt_idx    (evt_idx),
        .evt_ready  (evt_ready),
        .sel        (sel),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulses start and counts cycles until done (cycle 0 is the one after the start edge).
    task automatic run_ts(output int cyc, output int nevt, output int lidx, output int nvalid);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 0;
        nevt   = 0;
        nvalid = 0;
        lidx   = -1;
        while (!done && cyc < 50) begin
            if (evt_valid) nvalid++;
            if (evt_valid && evt_ready) begin
                nevt++;
                lidx = int'(evt_idx);
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc, nevt, lidx, nvalid;
        current_in = '0; thr_base = 8'd100; beta_shift = 3'd1; adapt_en = 1'b0;
        evt_ready = 1'b1; sel = '0;
        do_reset();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (spikes !== '0)      begin bad++; $display("FAIL reset_spikes got=%b exp=0", spikes); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_evt_valid got=%b exp=0", evt_valid); end
        total++; if (evt_idx !== '0)     begin bad++; $display("FAIL reset_evt_idx got=%0d exp=0", evt_idx); end
        total++; if (state_out !== '0)   begin bad++; $display("FAIL reset_state_out got=%0d exp=0", state_out); end
        run_ts(cyc, nevt, lidx, nvalid);
        total++; if (cyc !== N + 1)   begin bad++; $display("FAIL idle_latency got=%0d exp=%0d", cyc, N + 1); end
        total++; if (spikes !== '0)   begin bad++; $display("FAIL idle_spikes got=%b exp=0", spikes); end
        total++; if (nvalid !== 0)    begin bad++; $display("FAIL idle_evt_valid cycles got=%0d exp=0", nvalid); end
    endtask

    task automatic test_leak();
        int cyc, nevt, lidx, nvalid;
        int exp_v [3] = '{40, 60, 70};
        current_in = {8'd0, 8'd0, 8'd0, 8'd40}; thr_base = 8'd200; beta_shift = 3'd1;
        adapt_en = 1'b0; evt_ready = 1'b1; sel = 2'd0;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            run_ts(cyc, nevt, lidx, nvalid);
            total++;
            if (state_out !== W'(exp_v[t])) begin
                bad++; $display("FAIL leak_ts%0d got=%0d exp=%0d", t, state_out, exp_v[t]);
            end
        end
        total++; if (spikes !== '0) begin bad++; $display("FAIL leak_spikes got=%b exp=0", spikes); end
    endtask

    task automatic test_fire();
        int cyc, nevt, lidx, nvalid;
        current_in = {8'd0, 8'd120, 8'd0, 8'd0}; thr_base = 8'd100; beta_shift = 3'd1;
        adapt_en = 1'b0; evt_ready = 1'b1; sel = 2'd2;
        do_reset();
        run_ts(cyc, nevt, lidx, nvalid);
        total++; if (cyc !== N + 1)        begin bad++; $display("FAIL fire_latency got=%0d exp=%0d", cyc, N + 1); end
        total++; if (spikes !== 4'b0100)   begin bad++; $display("FAIL fire_spikes got=%b exp=0100", spikes); end
        total++; if (nevt !== 1)           begin bad++; $display("FAIL fire_evt_count got=%0d exp=1", nevt); end
        total++; if (lidx !== 2)           begin bad++; $display("FAIL fire_evt_idx got=%0d exp=2", lidx); end
        total++; if (state_out !== '0)     begin bad++; $display("FAIL fire_v2 got=%0d exp=0", state_out); end
        total++; if (evt_valid !== 1'b0)   begin bad++; $display("FAIL fire_slot_drained got=%b exp=0", evt_valid); end
    endtask

    task automatic test_stall();
        logic [8:0] pat;
        int c;
        pat = 9'b100101000;
        current_in = {N{8'd255}}; thr_base = 8'd10; beta_shift = 3'd0;
        adapt_en = 1'b0; evt_ready = 1'b0; sel = '0;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!done && c < 50) begin
            evt_ready = (c < 9) ? pat[c] : 1'b0;
            if (c == 3) begin
                total++;
                if (evt_valid !== 1'b1 || evt_idx !== 2'd0) begin
                    bad++; $display("FAIL stall_hold got valid=%b idx=%0d exp valid=1 idx=0", evt_valid, evt_idx);
                end
            end
            if (c == 4) begin
                total++;
                if (evt_valid !== 1'b1 || evt_idx !== 2'd1) begin
                    bad++; $display("FAIL stall_reload got valid=%b idx=%0d exp valid=1 idx=1", evt_valid, evt_idx);
                end
            end
            @(negedge clk);
            c++;
        end
        evt_ready = 1'b0;
        total++; if (c !== N + 1 + 5)   begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", c, N + 6); end
        total++; if (spikes !== 4'hF)   begin bad++; $display("FAIL stall_spikes got=%b exp=1111", spikes); end
        total++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd3) begin
            bad++; $display("FAIL stall_last_evt got valid=%b idx=%0d exp valid=1 idx=3", evt_valid, evt_idx);
        end
    endtask

    task automatic test_adapt();
        int cyc, nevt, lidx, nvalid;
        // columns: adapt_en, neuron-1 current, expected fire, expected membrane
        int tab [10][4] = '{
            '{1, 60, 1,  0}, '{1, 60, 0, 60}, '{1, 60, 0, 60}, '{1, 64, 1,  0},
            '{0, 79, 0, 79}, '{0, 79, 0, 79}, '{0, 80, 1,  0}, '{0, 80, 1,  0},
            '{1, 79, 0, 79}, '{1, 79, 1,  0}};
        thr_base = 8'd50; beta_shift = 3'd0; evt_ready = 1'b1; sel = 2'd1;
        current_in = '0; adapt_en = 1'b1;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            adapt_en   = tab[s][0][0];
            current_in = {8'd0, 8'd0, 8'(tab[s][1]), 8'd0};
            run_ts(cyc, nevt, lidx, nvalid);
            total++;
            if (spikes !== (tab[s][2] != 0 ? 4'b0010 : 4'b0000)) begin
                bad++; $display("FAIL adapt_spikes step%0d got=%b exp_fire=%0d", s, spikes, tab[s][2]);
            end
            total++;
            if (state_out !== W'(tab[s][3])) begin
                bad++; $display("FAIL adapt_v step%0d got=%0d exp=%0d", s, state_out, tab[s][3]);
            end
        end
    endtask

    task automatic test_abort_and_ignored_start();
        int cyc, nevt, lidx, nvalid, ndone, first;
        current_in = {8'd0, 8'd120, 8'd0, 8'd0}; thr_base = 8'd100; beta_shift = 3'd1;
        adapt_en = 1'b0; evt_ready = 1'b0; sel = 2'd2;
        do_reset();
        run_ts(cyc, nevt, lidx, nvalid);
        total++;
        if (spikes !== 4'b0100 || evt_valid !== 1'b1) begin
            bad++; $display("FAIL abort_setup got spikes=%b valid=%b exp spikes=0100 valid=1", spikes, evt_valid);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || spikes !== '0 || evt_valid !== 1'b0 || evt_idx !== '0) begin
            bad++; $display("FAIL abort_values got busy=%b done=%b spikes=%b valid=%b idx=%0d exp all 0",
                            busy, done, spikes, evt_valid, evt_idx);
        end
        ndone = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end

        current_in = '0; evt_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        ndone = 0;
        first = -1;
        for (int c = 0; c < 15; c++) begin
            start = (c == 2);
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (ndone !== 1)     begin bad++; $display("FAIL ignored_start_count got=%0d exp=1", ndone); end
        total++; if (first !== N + 1) begin bad++; $display("FAIL ignored_start_latency got=%0d exp=%0d", first, N + 1); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; current_in = '0; thr_base = '0; beta_shift = '0;
        adapt_en = 1'b0; evt_ready = 1'b0; sel = '0;
        test_reset();
        test_leak();
        test_fire();
        test_stall();
        test_adapt();
        test_abort_and_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed sequencer that shares one leaky-integrate-and-fire update datapath across `N` neurons. Each `start` pulse runs one timestep: neurons are updated in index order, one per cycle, against per-neuron membrane and adaptive-threshold registers. Spikes are reported as a registered spike vector and as a single-entry valid/ready event stream. Sits between the input-current front end and the spike/display outputs of the tile.

## Interface
- `N`, 4: number of neurons, 2..16.
- `W`, 8: membrane, current and threshold width.
- `THR_STEP`, 8'd16: adaptive-threshold increment per spike.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a timestep; honoured only in IDLE.
- `current_in`  in  N*W  per-neuron input current; neuron k is `[k*W +: W]`; sampled per neuron at its update cycle.
- `thr_base`  in  W  base firing threshold.
- `beta_shift`  in  3  leak shift.
- `adapt_en`  in  1  enable adaptive threshold.
- `busy`  out  1  high in UPDATE and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `spikes`  out  N  spike vector of the last completed timestep.
- `evt_valid`  out  1  spike event pending.
- `evt_idx`  out  $clog2(N)  index of the spiking neuron.
- `evt_ready`  in  1  consumer accepts the event.
- `sel`  in  $clog2(N)  neuron selected for observation.
- `state_out`  out  W  membrane of neuron `sel`, registered value.

## Operation
- FSM: IDLE -> UPDATE on `start`. UPDATE steps `idx` 0..N-1. After the commit of `idx = N-1`: -> DONE for one cycle, then -> IDLE.
- Update of neuron `idx`, all unsigned:
  - `leak = v >> beta_shift`; `v_l = v - leak`.
  - `sum = v_l + cur`, computed at W+1 bits and saturated to 2^W-1.
  - `eff_thr = min(thr_base + off, 2^W-1)`.
  - `fire = sum >= eff_thr`.
  - On `fire`, `v <= 0`; otherwise `v <= sum`.
- Adaptive offset `off[idx]`, W bits, updated only when `adapt_en` = 1:
  - On `fire`: `off += THR_STEP`, saturating.
  - Otherwise: `off -= 1`, floor 0.
  - When `adapt_en` = 0, `off` is held but still used in `eff_thr`.
- Working spike vector: cleared on entering UPDATE; bit `idx` is set on a firing commit. It is copied to `spikes` on the DONE transition.
- Event slot: a firing commit loads `evt_idx <= idx` and sets `evt_valid`. The slot clears on `evt_valid & evt_ready`.
- Stall: if `fire` and the slot is occupied and not draining this cycle, nothing is committed and `idx` holds. The same neuron is re-evaluated next cycle with a freshly sampled `current_in`.
- If the slot is draining in the same cycle as a firing commit, the commit proceeds and the slot reloads, so `evt_valid` stays high.
- `start` while busy is ignored. The event slot may still be pending in IDLE; the next timestep may start regardless.

## Timing
- Reset values:
  - FSM = IDLE, `idx` = 0.
  - All `v` = 0, all `off` = 0.
  - `spikes` = 0, `evt_valid` = 0, `evt_idx` = 0.
  - `busy` = 0, `done` = 0, `state_out` = 0.
- `start` is sampled at edge E0. Neuron k commits at edge E(k+1) when there are no stalls. `done` is high in the cycle after edge E(N+1), and `spikes` is valid from that same edge.
- Unstalled timestep latency: N+1 cycles from `start` to `done`. Each stall adds exactly one cycle.
- `evt_valid` rises the cycle after the firing commit edge.
- `state_out` reflects a commit one cycle after the commit edge.
- Reset mid-timestep aborts immediately. All state returns to reset values and no `done` is issued.

## Structure
- Package `lif_pkg`:
  - FSM state enum `{IDLE, UPDATE, DONE}`.
  - Default W and N.
  - `sat_add` / `sat_sub` helper functions.
- Sub-module `lif_core`: purely combinational datapath. Inputs `v`, `cur`, `off`, `thr_base`, `beta_shift`, `adapt_en`. Outputs `v_next`, `off_next`, `fire`.
- `lif_scheduler`: holds the FSM, membrane and offset register files, the spike vector and the event slot.

## Test plan
- **Reset and output values.** After reset, check all outputs are 0. Pulse `start` with currents 0, `thr_base` = 100 -> `done` at cycle N+1, `spikes` = 0, `evt_valid` never set.
- **Leak and integrate.** Set `beta_shift` = 1, `thr_base` = 200, neuron 0 current 40, run 3 timesteps -> `state_out`(sel=0) = 40, 60, 70.
- **Fire, event and reset.** Set neuron 2 current 120, `thr_base` = 100, `evt_ready` = 1 -> `spikes` = 4'b0100, one event with `evt_idx` = 2, neuron 2 `v` = 0.
- **Stall under backpressure.** Set `evt_ready` = 0, all currents 255, `thr_base` = 10 -> neuron 0 commits, then the scheduler stalls at `idx` = 1. Raise `evt_ready` for one cycle -> neuron 1 commits. Check total latency equals N+1 plus the number of stall cycles.
- **Adaptive threshold.** Set `adapt_en` = 1, `thr_base` = 50, neuron 1 current 60 -> it fires in timestep 1, then `eff_thr` = 66 and it does not fire in timestep 2. `off` decays 16 -> 15 -> 14. Repeat with `adapt_en` = 0 -> `off` is held.
- **Abort and ignored start.** Deassert `rst_n` while `idx` = 2 -> immediate reset values, no `done`. Assert `start` during UPDATE -> ignored, and the timestep count is unchanged.
